dram_sequencer: RTL

DRAM_SEQUENCER -- requirements
Module: dram_sequencer

---
 rtl/dram_pkg.sv | 23 ++
 rtl/dram_sequencer_refresh_timer.sv | 61 ++++++
 rtl/dram_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the FASTRAM DRAM sequencer: state encoding and
// default timing parameters.
package dram_pkg;

    // About 15.5 us between refresh ticks at a 14.18 MHz CPU clock
    localparam int DEFAULT_REFRESH_INTERVAL = 220;

    // Owed refreshes allowed to pile up before refresh pre-empts accesses
    localparam int DEFAULT_MAX_PENDING = 4;

    typedef enum logic [3:0] {
        IDLE,
        ROW,
        COL,
        STROBE,
        PRE,
        CBR_CAS,
        CBR_RAS1,
        CBR_RAS2,
        CBR_PRE
    } dram_state_e;

endpackage

// File: rtl/dram_sequencer_refresh_timer.sv
// Refresh interval timer plus the count of refreshes owed to the DRAM.
// A sticky overrun flag records any tick that could not be counted.
module refresh_timer
    import dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEFAULT_MAX_PENDING
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_done,
    output logic [2:0] pend,
    output logic       refresh_overrun
);

    localparam int               CNT_W  = ($clog2(REFRESH_INTERVAL) > 0) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [2:0]       MAX_P  = 3'(MAX_PENDING);

    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       pend_q, pend_d;
    logic             overrun_q, overrun_d;
    logic             tick;

    // Count down to zero, reload, and keep the owed count in step with ticks and completed refreshes
    always_comb begin
        tick      = (count_q == '0);
        count_d   = tick ? RELOAD : count_q - CNT_W'(1);
        pend_d    = pend_q;
        overrun_d = overrun_q;
        if (tick && !refresh_done) begin
            if (pend_q == MAX_P) begin
                overrun_d = 1'b1;
            end else begin
                pend_d = pend_q + 3'd1;
            end
        end else if (refresh_done && !tick) begin
            if (pend_q != 3'd0) begin
                pend_d = pend_q - 3'd1;
            end
        end
    end

    // Timer, owed count and overrun flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= RELOAD;
            pend_q    <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    assign pend            = pend_q;
    assign refresh_overrun = overrun_q;

endmodule

// File: rtl/dram_sequencer.sv
// FASTRAM DRAM sequencer: arbitrates CPU accesses against CAS-before-RAS
// refresh and drives the RAS/CAS/mux/OE strobes from the current state.
module dram_sequencer
    import dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEFAULT_MAX_PENDING
)
(
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       REQ,
    input  logic       RW,
    input  logic       BANK,
    input  logic [3:0] BYTE_EN,
    output logic       ACK,
    output logic [1:0] RAS_N,
    output logic [3:0] CAS_N,
    output logic       RAM_MUX,
    output logic       RAMOE_N,
    output logic       BUSY,
    output logic       REFRESH_OVERRUN
);

    localparam logic [2:0] MAX_P = 3'(MAX_PENDING);

    dram_state_e state_q, state_d;
    logic        rw_q, rw_d;
    logic        bank_q, bank_d;
    logic [3:0]  byte_en_q, byte_en_d;
    logic [2:0]  pend;
    logic        refresh_done;
    logic [1:0]  row_ras_n;

    refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL),
        .MAX_PENDING     (MAX_PENDING)
    ) u_refresh (
        .clk            (CLKCPU),
        .reset          (RESET),
        .refresh_done   (refresh_done),
        .pend           (pend),
        .refresh_overrun(REFRESH_OVERRUN)
    );

    // Next-state arbitration and strobe decode; strobes idle unless a state drives them
    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        bank_d       = bank_q;
        byte_en_d    = byte_en_q;
        refresh_done = 1'b0;
        ACK          = 1'b0;
        RAS_N        = 2'b11;
        CAS_N        = 4'b1111;
        RAM_MUX      = 1'b1;
        RAMOE_N      = 1'b1;
        BUSY         = (state_q != IDLE);
        row_ras_n    = bank_q ? 2'b01 : 2'b10;

        case (state_q)
            IDLE: begin
                if (pend == MAX_P) begin
                    state_d = CBR_CAS;
                end else if (REQ) begin
                    rw_d      = RW;
                    bank_d    = BANK;
                    byte_en_d = BYTE_EN;
                    state_d   = ROW;
                end else if (pend != 3'd0) begin
                    state_d = CBR_CAS;
                end
            end
            ROW: begin
                RAS_N   = row_ras_n;
                RAMOE_N = ~rw_q;
                state_d = COL;
            end
            COL: begin
                RAS_N   = row_ras_n;
                RAMOE_N = ~rw_q;
                RAM_MUX = 1'b0;
                state_d = STROBE;
            end
            STROBE: begin
                RAS_N   = row_ras_n;
                RAMOE_N = ~rw_q;
                RAM_MUX = 1'b0;
                CAS_N   = ~byte_en_q;
                ACK     = 1'b1;
                state_d = PRE;
            end
            PRE: begin
                if (!REQ) begin
                    state_d = IDLE;
                end
            end
            CBR_CAS: begin
                CAS_N   = 4'b0000;
                state_d = CBR_RAS1;
            end
            CBR_RAS1: begin
                CAS_N   = 4'b0000;
                RAS_N   = 2'b00;
                state_d = CBR_RAS2;
            end
            CBR_RAS2: begin
                CAS_N   = 4'b0000;
                RAS_N   = 2'b00;
                state_d = CBR_PRE;
            end
            CBR_PRE: begin
                refresh_done = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched access attributes
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q   <= IDLE;
            rw_q      <= 1'b0;
            bank_q    <= 1'b0;
            byte_en_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            bank_q    <= bank_d;
            byte_en_q <= byte_en_d;
        end
    end

endmodule
